// File: rtl/osd_cdm_pkg.sv
// rtl/osd_cdm_pkg.sv - shared constants, event codes and FSM state type for the CDM bridge
package osd_cdm_pkg;

  localparam logic [15:0] CDM_REG_CORE_CTRL      = 16'h0200;
  localparam logic [15:0] CDM_REG_CORE_REG_UPPER = 16'h0201;
  localparam logic [15:0] CDM_REG_STATUS         = 16'h0202;
  localparam logic [15:0] CDM_CORE_SPACE_BASE    = 16'h8000;

  localparam logic [15:0] EV_STALL  = 16'h0001;
  localparam logic [15:0] EV_RESUME = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } cdm_state_t;

endpackage

// File: rtl/osd_cdm_event_buf.sv
// rtl/osd_cdm_event_buf.sv - stall/resume edge detect feeding a one-deep event buffer
module osd_cdm_event_buf
  import osd_cdm_pkg::*;
#(
  parameter int EVENT_ON_RESUME = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        du_stall_o,
  input  logic        event_consumed,
  output logic        event_available,
  output logic [15:0] event_data,
  output logic        event_overflow
);

  logic stall_q;
  logic rise;
  logic fall;
  logic ev_fire;

  assign rise    = du_stall_o & ~stall_q;
  assign fall    = ~du_stall_o & stall_q & (EVENT_ON_RESUME != 0);
  assign ev_fire = rise | fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q         <= 1'b0;
      event_available <= 1'b0;
      event_data      <= 16'h0000;
      event_overflow  <= 1'b0;
    end else begin
      stall_q        <= du_stall_o;
      event_overflow <= 1'b0;
      if (ev_fire) begin
        event_data      <= rise ? EV_STALL : EV_RESUME;
        event_available <= 1'b1;
        // A concurrent consume frees the slot, so only an unconsumed pending event counts as lost.
        event_overflow  <= event_available & ~event_consumed;
      end else if (event_consumed) begin
        event_available <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/osd_cdm_bridge.sv
// rtl/osd_cdm_bridge.sv - OSD register access to CPU debug-unit bus bridge with watchdog and stall events
module osd_cdm_bridge
  import osd_cdm_pkg::*;
#(
  parameter int CORE_DATA_WIDTH      = 32,
  parameter int CORE_ADDR_WIDTH      = 16,
  parameter int CORE_REG_UPPER_RESET = 0,
  parameter int TIMEOUT_CYCLES       = 256,
  parameter int EVENT_ON_RESUME      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reg_request,
  input  logic                       reg_write,
  input  logic [15:0]                reg_addr,
  input  logic [CORE_DATA_WIDTH-1:0] reg_wdata,
  output logic                       reg_ack,
  output logic                       reg_err,
  output logic [CORE_DATA_WIDTH-1:0] reg_rdata,
  output logic                       du_stall_i,
  input  logic                       du_stall_o,
  output logic                       du_stb_i,
  input  logic                       du_ack_o,
  output logic [CORE_ADDR_WIDTH-1:0] du_adr_i,
  output logic                       du_we_i,
  output logic [CORE_DATA_WIDTH-1:0] du_dat_i,
  input  logic [CORE_DATA_WIDTH-1:0] du_dat_o,
  output logic                       event_available,
  input  logic                       event_consumed,
  output logic [15:0]                event_data,
  output logic                       event_overflow
);

  localparam int          UPPER_W = CORE_ADDR_WIDTH - 15;
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  cdm_state_t         state;
  logic [UPPER_W-1:0] core_reg_upper;
  logic               timeout_sticky;
  logic [31:0]        wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      core_reg_upper <= UPPER_W'(CORE_REG_UPPER_RESET);
      timeout_sticky <= 1'b0;
      wd_cnt         <= 32'd0;
      reg_ack        <= 1'b0;
      reg_err        <= 1'b0;
      reg_rdata      <= '0;
      du_stall_i     <= 1'b0;
      du_stb_i       <= 1'b0;
      du_adr_i       <= '0;
      du_we_i        <= 1'b0;
      du_dat_i       <= '0;
    end else begin
      reg_ack <= 1'b0;
      reg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (reg_request) begin
            state <= ST_RESP;
            if (reg_addr[15]) begin
              du_adr_i <= {core_reg_upper, reg_addr[14:0]};
              du_we_i  <= reg_write;
              du_dat_i <= reg_write ? reg_wdata : '0;
              du_stb_i <= 1'b1;
              wd_cnt   <= 32'd0;
              state    <= ST_BUS;
            end else if (reg_addr == CDM_REG_CORE_CTRL) begin
              reg_ack <= 1'b1;
              if (reg_write) du_stall_i <= reg_wdata[0];
              else           reg_rdata  <= CORE_DATA_WIDTH'(du_stall_i);
            end else if (reg_addr == CDM_REG_CORE_REG_UPPER) begin
              reg_ack <= 1'b1;
              if (reg_write) core_reg_upper <= reg_wdata[UPPER_W-1:0];
              else           reg_rdata      <= CORE_DATA_WIDTH'(core_reg_upper);
            end else if (reg_addr == CDM_REG_STATUS && !reg_write) begin
              reg_ack        <= 1'b1;
              reg_rdata      <= CORE_DATA_WIDTH'({timeout_sticky, du_stall_o});
              timeout_sticky <= 1'b0;
            end else begin
              reg_err <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          // Ack is tested first so a late ack on the final watchdog cycle still completes.
          if (du_ack_o) begin
            du_stb_i <= 1'b0;
            reg_ack  <= 1'b1;
            if (!du_we_i) reg_rdata <= du_dat_o;
            state <= ST_RESP;
          end else if (WD_EN && wd_cnt == WD_LAST) begin
            du_stb_i       <= 1'b0;
            reg_err        <= 1'b1;
            timeout_sticky <= 1'b1;
            state          <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  osd_cdm_event_buf #(
    .EVENT_ON_RESUME(EVENT_ON_RESUME)
  ) u_event_buf (
    .clk            (clk),
    .rst            (rst),
    .du_stall_o     (du_stall_o),
    .event_consumed (event_consumed),
    .event_available(event_available),
    .event_data     (event_data),
    .event_overflow (event_overflow)
  );

endmodule

// File: tb/tb_osd_cdm_bridge.sv
// tb/tb_osd_cdm_bridge.sv - directed self-checking bench for osd_cdm_bridge
module tb_osd_cdm_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_request = 1'b0;
  logic        reg_write = 1'b0;
  logic [15:0] reg_addr = 16'h0;
  logic [31:0] reg_wdata = 32'h0;
  logic        reg_ack;
  logic        reg_err;
  logic [31:0] reg_rdata;
  logic        du_stall_i;
  logic        du_stall_o = 1'b0;
  logic        du_stb_i;
  logic        du_ack_o = 1'b0;
  logic [15:0] du_adr_i;
  logic        du_we_i;
  logic [31:0] du_dat_i;
  logic [31:0] du_dat_o = 32'h0;
  logic        event_available;
  logic        event_consumed = 1'b0;
  logic [15:0] event_data;
  logic        event_overflow;

  int checks = 0;
  int errors = 0;

  osd_cdm_bridge #(
    .CORE_DATA_WIDTH(32), .CORE_ADDR_WIDTH(16), .CORE_REG_UPPER_RESET(0),
    .TIMEOUT_CYCLES(8), .EVENT_ON_RESUME(1)
  ) dut (
    .clk(clk), .rst(rst),
    .reg_request(reg_request), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata),
    .du_stall_i(du_stall_i), .du_stall_o(du_stall_o), .du_stb_i(du_stb_i),
    .du_ack_o(du_ack_o), .du_adr_i(du_adr_i), .du_we_i(du_we_i),
    .du_dat_i(du_dat_i), .du_dat_o(du_dat_o),
    .event_available(event_available), .event_consumed(event_consumed),
    .event_data(event_data), .event_overflow(event_overflow)
  );

  always #5 clk = ~clk;

  task automatic start_req(input logic w, input logic [15:0] a, input logic [31:0] d);
    reg_request = 1'b1;
    reg_write   = w;
    reg_addr    = a;
    reg_wdata   = d;
  endtask

  // Request drops here; the FSM is in RESP on the next edge so it is never re-accepted.
  task automatic end_req();
    reg_request = 1'b0;
    reg_write   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({reg_ack, reg_err, du_stb_i, du_stall_i, du_we_i} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {reg_ack, reg_err, du_stb_i, du_stall_i, du_we_i});
    end
    checks++; if (reg_rdata !== 32'h0 || du_adr_i !== 16'h0 || du_dat_i !== 32'h0) begin
      errors++; $display("FAIL reset_data: rdata=%h adr=%h dat=%h want 0", reg_rdata, du_adr_i, du_dat_i);
    end
    checks++; if ({event_available, event_overflow} !== 2'b0 || event_data !== 16'h0) begin
      errors++; $display("FAIL reset_event: avail=%b ovf=%b data=%h want 0", event_available, event_overflow, event_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_local();
    start_req(1'b1, 16'h0200, 32'h1);
    @(negedge clk);
    checks++; if (reg_ack !== 1'b1 || reg_err !== 1'b0 || du_stall_i !== 1'b1) begin
      errors++; $display("FAIL ctrl_write: ack=%b err=%b stall_i=%b want 1 0 1", reg_ack, reg_err, du_stall_i);
    end
    end_req();
    start_req(1'b0, 16'h0200, 32'h0);
    @(negedge clk);
    checks++; if (reg_ack !== 1'b1 || reg_rdata !== 32'h1) begin
      errors++; $display("FAIL ctrl_read: ack=%b rdata=%h want 1 00000001", reg_ack, reg_rdata);
    end
    end_req();
    checks++; if (reg_ack !== 1'b0) begin
      errors++; $display("FAIL ack_one_cycle: ack=%b want 0", reg_ack);
    end
    start_req(1'b1, 16'h0201, 32'hFFFF_FFFF);
    @(negedge clk);
    end_req();
    start_req(1'b0, 16'h0201, 32'h0);
    @(negedge clk);
    checks++; if (reg_ack !== 1'b1 || reg_rdata !== 32'h1) begin
      errors++; $display("FAIL upper_trunc: ack=%b rdata=%h want 1 00000001", reg_ack, reg_rdata);
    end
    end_req();
  endtask

  task automatic test_core_read();
    start_req(1'b0, 16'h8005, 32'h0);
    @(negedge clk);
    checks++; if (du_stb_i !== 1'b1 || du_adr_i !== 16'h8005 || du_we_i !== 1'b0 || du_dat_i !== 32'h0) begin
      errors++; $display("FAIL core_rd_bus: stb=%b adr=%h we=%b dat=%h want 1 8005 0 0", du_stb_i, du_adr_i, du_we_i, du_dat_i);
    end
    repeat (2) @(negedge clk);
    checks++; if (du_stb_i !== 1'b1 || reg_ack !== 1'b0 || du_adr_i !== 16'h8005) begin
      errors++; $display("FAIL core_rd_hold: stb=%b ack=%b adr=%h want 1 0 8005", du_stb_i, reg_ack, du_adr_i);
    end
    du_ack_o = 1'b1;
    du_dat_o = 32'hDEAD_BEEF;
    @(negedge clk);
    du_ack_o = 1'b0;
    du_dat_o = 32'h0;
    checks++; if (reg_ack !== 1'b1 || reg_rdata !== 32'hDEAD_BEEF || du_stb_i !== 1'b0) begin
      errors++; $display("FAIL core_rd_resp: ack=%b rdata=%h stb=%b want 1 deadbeef 0", reg_ack, reg_rdata, du_stb_i);
    end
    end_req();
  endtask

  task automatic test_core_write();
    start_req(1'b1, 16'h0201, 32'h0);
    @(negedge clk);
    end_req();
    start_req(1'b1, 16'h9000, 32'h1234_5678);
    @(negedge clk);
    checks++; if (du_stb_i !== 1'b1 || du_we_i !== 1'b1 || du_dat_i !== 32'h1234_5678 || du_adr_i !== 16'h1000) begin
      errors++; $display("FAIL core_wr_bus: stb=%b we=%b dat=%h adr=%h want 1 1 12345678 1000", du_stb_i, du_we_i, du_dat_i, du_adr_i);
    end
    du_ack_o = 1'b1;
    du_dat_o = 32'hAAAA_5555;
    @(negedge clk);
    du_ack_o = 1'b0;
    checks++; if (reg_ack !== 1'b1 || du_stb_i !== 1'b0 || reg_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL core_wr_resp: ack=%b stb=%b rdata=%h want 1 0 deadbeef", reg_ack, du_stb_i, reg_rdata);
    end
    end_req();
  endtask

  task automatic test_timeout();
    int n = 0;
    start_req(1'b0, 16'h8000, 32'h0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (du_stb_i) n++;
      else break;
    end
    checks++; if (n !== 8 || reg_err !== 1'b1 || reg_ack !== 1'b0) begin
      errors++; $display("FAIL timeout: stb_cycles=%0d err=%b ack=%b want 8 1 0", n, reg_err, reg_ack);
    end
    end_req();
    checks++; if (reg_err !== 1'b0) begin
      errors++; $display("FAIL err_one_cycle: err=%b want 0", reg_err);
    end
    start_req(1'b0, 16'h0202, 32'h0);
    @(negedge clk);
    checks++; if (reg_ack !== 1'b1 || reg_rdata !== 32'h2) begin
      errors++; $display("FAIL status_sticky: ack=%b rdata=%h want 1 00000002", reg_ack, reg_rdata);
    end
    end_req();
    start_req(1'b0, 16'h0202, 32'h0);
    @(negedge clk);
    checks++; if (reg_ack !== 1'b1 || reg_rdata !== 32'h0) begin
      errors++; $display("FAIL status_clear: ack=%b rdata=%h want 1 00000000", reg_ack, reg_rdata);
    end
    end_req();
  endtask

  task automatic test_errors();
    start_req(1'b0, 16'h0100, 32'h0);
    @(negedge clk);
    checks++; if (reg_err !== 1'b1 || reg_ack !== 1'b0 || du_stb_i !== 1'b0) begin
      errors++; $display("FAIL bad_addr: err=%b ack=%b stb=%b want 1 0 0", reg_err, reg_ack, du_stb_i);
    end
    end_req();
    start_req(1'b1, 16'h0202, 32'h3);
    @(negedge clk);
    checks++; if (reg_err !== 1'b1 || reg_ack !== 1'b0 || du_stb_i !== 1'b0) begin
      errors++; $display("FAIL status_write: err=%b ack=%b stb=%b want 1 0 0", reg_err, reg_ack, du_stb_i);
    end
    end_req();
  endtask

  task automatic test_events();
    du_stall_o = 1'b1;
    @(negedge clk);
    checks++; if (event_available !== 1'b1 || event_data !== 16'h0001 || event_overflow !== 1'b0) begin
      errors++; $display("FAIL ev_stall: avail=%b data=%h ovf=%b want 1 0001 0", event_available, event_data, event_overflow);
    end
    du_stall_o = 1'b0;
    @(negedge clk);
    checks++; if (event_available !== 1'b1 || event_data !== 16'h0000 || event_overflow !== 1'b1) begin
      errors++; $display("FAIL ev_overwrite: avail=%b data=%h ovf=%b want 1 0000 1", event_available, event_data, event_overflow);
    end
    @(negedge clk);
    checks++; if (event_overflow !== 1'b0 || event_available !== 1'b1) begin
      errors++; $display("FAIL ev_ovf_pulse: ovf=%b avail=%b want 0 1", event_overflow, event_available);
    end
    event_consumed = 1'b1;
    @(negedge clk);
    event_consumed = 1'b0;
    checks++; if (event_available !== 1'b0) begin
      errors++; $display("FAIL ev_consume: avail=%b want 0", event_available);
    end
    du_stall_o = 1'b1;
    @(negedge clk);
    du_stall_o = 1'b0;
    event_consumed = 1'b1;
    @(negedge clk);
    event_consumed = 1'b0;
    checks++; if (event_available !== 1'b1 || event_data !== 16'h0000 || event_overflow !== 1'b0) begin
      errors++; $display("FAIL ev_coincident: avail=%b data=%h ovf=%b want 1 0000 0", event_available, event_data, event_overflow);
    end
    event_consumed = 1'b1;
    @(negedge clk);
    event_consumed = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    logic seen = 1'b0;
    start_req(1'b0, 16'h8000, 32'h0);
    @(negedge clk);
    checks++; if (du_stb_i !== 1'b1) begin
      errors++; $display("FAIL rst_bus_start: stb=%b want 1", du_stb_i);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reg_request = 1'b0;
    checks++; if (du_stb_i !== 1'b0 || reg_ack !== 1'b0 || reg_err !== 1'b0) begin
      errors++; $display("FAIL rst_bus_drop: stb=%b ack=%b err=%b want 0 0 0", du_stb_i, reg_ack, reg_err);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (reg_ack || reg_err || du_stb_i) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_bus_quiet: activity=%b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_local();
    test_core_read();
    test_core_write();
    test_timeout();
    test_errors();
    test_events();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_cdm_bridge.md
Name: osd_cdm_bridge

Overview:
Parametrised core-debug bridge between the OSD register-access layer (request/ack side) and a CPU debug-unit bus (du_*). It generalises core data width, core address width and upper-address paging. It adds a bus-timeout watchdog, a status register, and buffered stall/resume event generation toward an event packetizer. It is instantiated inside the CDM top beside osd_regaccess_layer and osd_event_packetization_fixedwidth.

Parameters:
CORE_DATA_WIDTH, 32, width of du_dat_*, reg_wdata and reg_rdata (16..64).
CORE_ADDR_WIDTH, 16, width of du_adr_i; must be >= 16.
CORE_REG_UPPER_RESET, 0, reset value of the CORE_REG_UPPER page register.
TIMEOUT_CYCLES, 256, cycles of du_stb_i without du_ack_o before abort; 0 disables the watchdog.
EVENT_ON_RESUME, 1, when 1 a falling edge of du_stall_o also produces an event.

Ports:
clk  in  1  clock
rst  in  1  reset
reg_request  in  1  access request, held until reg_ack or reg_err
reg_write  in  1  1 = write, 0 = read
reg_addr  in  16  register address
reg_wdata  in  CORE_DATA_WIDTH  write data
reg_ack  out  1  one-cycle completion pulse
reg_err  out  1  one-cycle error pulse
reg_rdata  out  CORE_DATA_WIDTH  read data, valid with reg_ack
du_stall_i  out  1  stall request to CPU
du_stall_o  in  1  CPU stalled (breakpoint/halt)
du_stb_i  out  1  debug bus strobe
du_ack_o  in  1  debug bus acknowledge
du_adr_i  out  CORE_ADDR_WIDTH  CPU register address
du_we_i  out  1  write enable
du_dat_i  out  CORE_DATA_WIDTH  write data to CPU
du_dat_o  in  CORE_DATA_WIDTH  read data from CPU
event_available  out  1  event pending for packetizer
event_consumed  in  1  packetizer took event
event_data  out  16  event word
event_overflow  out  1  one-cycle pulse: pending event overwritten

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. All outputs reset to 0. CORE_REG_UPPER resets to CORE_REG_UPPER_RESET. Timeout sticky, edge-detect register and FSM reset to 0/IDLE. Reset during a bus cycle drops du_stb_i on the next edge; no ack or err is issued.
- Register map (reg_addr):
  - 0x200 CORE_CTRL: bit0 = stall, driving du_stall_i directly. Read returns the bit zero-extended.
  - 0x201 CORE_REG_UPPER: width CORE_ADDR_WIDTH-15 bits. Writes truncate; reads zero-extend.
  - 0x202 STATUS, read-only: bit0 = du_stall_o, bit1 = timeout sticky. A read clears the sticky in the same cycle reg_ack is driven. A write gives reg_err.
  - 0x8000-0xFFFF: core access with du_adr_i = {CORE_REG_UPPER, reg_addr[14:0]}.
  - Any other address gives reg_err with no side effect.
- FSM states: IDLE, BUS, RESP.
  - IDLE: on reg_request, local registers update and reg_rdata is loaded, then go to RESP. Local access latency: request seen at edge N, reg_ack high during cycle N+1.
  - IDLE, core range: register du_adr_i and du_we_i = reg_write. du_dat_i = reg_wdata for writes, 0 for reads. Assert du_stb_i and go to BUS.
  - BUS: hold du_stb_i, du_adr_i, du_we_i and du_dat_i stable. Watchdog counter increments every cycle.
    - du_ack_o=1: deassert du_stb_i, capture du_dat_o into reg_rdata (reads only), go to RESP with ack.
    - Counter reaches TIMEOUT_CYCLES with no ack: deassert du_stb_i, set timeout sticky, go to RESP with err.
    - Ack and timeout in the same cycle: ack wins.
  - RESP: exactly one of reg_ack/reg_err high for one cycle, then IDLE. A new request is accepted no earlier than the cycle after RESP.
- reg_rdata holds its value until the next response.
- Stall events:
  - Edge detect on du_stall_o with a one-cycle registered delay.
  - Rising edge loads event_data = 0x0001. Falling edge loads 0x0000, only if EVENT_ON_RESUME.
  - event_available is set on the cycle after the edge and cleared when event_consumed is sampled high.
  - One-deep buffer. A new edge while pending overwrites event_data and pulses event_overflow.
  - Edge coincident with consume: new event loaded, event_available stays 1, no overflow.
- du_stall_i is independent of the FSM. The CPU may be stalled while core accesses proceed.

Decomposition:
- Package osd_cdm_pkg: address constants CDM_REG_CORE_CTRL=0x200, CDM_REG_CORE_REG_UPPER=0x201, CDM_REG_STATUS=0x202, CDM_CORE_SPACE_BASE=0x8000; event codes EV_STALL=0x0001, EV_RESUME=0x0000; FSM state enum.
- One sub-module: osd_cdm_event_buf (edge detect plus one-deep event buffer with overflow).

Test Plan:
- Write 0x200 = 1, then read 0x200 -> du_stall_i=1 one cycle after request; read returns 1, reg_ack one cycle after request.
- CORE_REG_UPPER=1, read 0x8005; CPU acks after 3 cycles with 0xDEADBEEF -> du_adr_i=0x8005, du_we_i=0; reg_rdata=0xDEADBEEF with reg_ack one cycle after du_ack_o.
- Write 0x9000 data 0x12345678 -> du_we_i=1, du_dat_i=0x12345678, du_adr_i=0x1000 (upper=0); strobe drops after ack.
- TIMEOUT_CYCLES=8, no du_ack_o -> du_stb_i drops after 8 cycles; reg_err pulse; STATUS read = 0x2, second STATUS read = 0x0.
- du_stall_o 0->1 with event_consumed low, then 1->0 -> event_data 0x0001 then 0x0000; event_overflow pulses once; event_available stays 1.
- Read 0x0100 and write 0x202 -> reg_err each; no du_stb_i; rst asserted mid-BUS -> du_stb_i=0 next cycle, no ack or err.
